// File: rtl/multiplier_sequential.sv
// Radix-2 sequential shift-add multiplier, signed or unsigned, fixed WIDTH-cycle latency.
// Signed operands are multiplied as magnitudes and the product is negated at the end when needed.
module multiplier_sequential #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 Clock_In,
   input  logic                 Reset_N_In,
   input  logic                 Start_In,
   input  logic                 Signed_In,
   input  logic [WIDTH-1:0]     Data_A_In,
   input  logic [WIDTH-1:0]     Data_B_In,
   output logic                 Ready_Out,
   output logic                 Done_Out,
   output logic [2*WIDTH-1:0]   Multiplied_Result_Out
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;

   logic [WIDTH:0]     step_sum;
   logic [2*WIDTH-1:0] step_prod;
   logic               a_neg, b_neg;

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      result_d  = result_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      ready_d   = ready_q;
      done_d    = done_q;

      a_neg     = Signed_In & Data_A_In[WIDTH-1];
      b_neg     = Signed_In & Data_B_In[WIDTH-1];

      // Upper half accumulates; the multiplier sits in the lower half and shifts out through bit 0.
      step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      step_prod = {step_sum, prod_q[WIDTH-1:1]};

      case (state_q)
         IDLE: begin
            if (Start_In) begin
               mcand_d = a_neg ? -Data_A_In : Data_A_In;
               prod_d  = {{WIDTH{1'b0}}, (b_neg ? -Data_B_In : Data_B_In)};
               neg_d   = a_neg ^ b_neg;
               cnt_d   = CW'(WIDTH);
               ready_d = 1'b0;
               state_d = CALC;
            end
         end
         CALC: begin
            prod_d = step_prod;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               result_d = neg_q ? -step_prod : step_prod;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: begin
            done_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         prod_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   assign Ready_Out             = ready_q;
   assign Done_Out              = done_q;
   assign Multiplied_Result_Out = result_q;

endmodule

// File: tb/tb_multiplier_sequential.sv
// Directed-vector and random bench for multiplier_sequential at WIDTH=32.
module tb_multiplier_sequential;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sgn_in;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        ready;
   logic        done;
   logic [63:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   multiplier_sequential #(.WIDTH(32)) dut (
      .Clock_In              (clk),
      .Reset_N_In            (rst_n),
      .Start_In              (start),
      .Signed_In             (sgn_in),
      .Data_A_In             (a_in),
      .Data_B_In             (b_in),
      .Ready_Out             (ready),
      .Done_Out              (done),
      .Multiplied_Result_Out (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[11];

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Runs one operation; after the accept edge Start is left at 'hold' and the operands are
   // replaced by na/nb, which the DUT must ignore while busy.
   task automatic run_op(input string name, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit hold, input logic [31:0] na,
                         input logic [31:0] nb);
      int unsigned n;
      bit          seen;
      bit          changed;
      logic [63:0] prev;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready_idle"}, ready, 1);
      sgn_in = sgn;
      a_in   = a;
      b_in   = b;
      start  = 1'b1;
      prev   = result;
      @(negedge clk);
      check({name, "_ready_busy"}, ready, 0);
      start  = hold;
      a_in   = na;
      b_in   = nb;
      sgn_in = ~sgn;
      n = 0;
      seen = 1'b0;
      changed = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (done) seen = 1'b1;
         else if (result !== prev) changed = 1'b1;
      end
      check({name, "_latency"}, 64'(n), 64'd32);
      check({name, "_hold_in_calc"}, 64'(changed), 64'd0);
      check({name, "_result"}, result, exp);
      @(negedge clk);
      check({name, "_done_pulse"}, 64'(done), 64'd0);
      check({name, "_ready_after"}, 64'(ready), 64'd1);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [63:0] rexp;
      bit          rs;
      int unsigned n;
      bit          seen;

      vecs[0]  = '{"u_3x5",       1'b0, 32'd3,        32'd5,        64'h0000_0000_0000_000F};
      vecs[1]  = '{"u_ffxff",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[2]  = '{"s_m1xm1",     1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000_0000_0000_0001};
      vecs[3]  = '{"s_minxmin",   1'b1, 32'h80000000, 32'h80000000, 64'h4000_0000_0000_0000};
      vecs[4]  = '{"s_minx1",     1'b1, 32'h80000000, 32'd1,        64'hFFFF_FFFF_8000_0000};
      vecs[5]  = '{"u_zero",      1'b0, 32'd0,        32'h12345678, 64'h0};
      vecs[6]  = '{"s_m3x5",      1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1};
      vecs[7]  = '{"u_minx2",     1'b0, 32'h80000000, 32'd2,        64'h0000_0001_0000_0000};
      vecs[8]  = '{"s_maxxmin",   1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000_0000_8000_0000};
      vecs[9]  = '{"u_x16",       1'b0, 32'h12345678, 32'h10,       64'h0000_0001_2345_6780};
      vecs[10] = '{"s_zero_neg",  1'b1, 32'hFFFFFFFF, 32'd0,        64'h0};

      rst_n  = 1'b0;
      start  = 1'b0;
      sgn_in = 1'b0;
      a_in   = '0;
      b_in   = '0;
      repeat (3) @(negedge clk);
      check("rst_ready",  64'(ready), 64'd1);
      check("rst_done",   64'(done),  64'd0);
      check("rst_result", result,     64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++)
         run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0,
                32'hDEADBEEF, 32'hCAFEF00D);

      // Start held high through CALC/DONE with different operands on the bus.
      run_op("held", 1'b0, 32'd9, 32'd11, 64'd99, 1'b1, 32'd2, 32'd2);
      run_op("held_next", 1'b0, 32'd2, 32'd2, 64'd4, 1'b0, 32'd0, 32'd0);

      // Reset in the middle of CALC.
      @(negedge clk);
      sgn_in = 1'b0;
      a_in   = 32'h1234;
      b_in   = 32'h5678;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_ready",  64'(ready), 64'd1);
      check("midrst_done",   64'(done),  64'd0);
      check("midrst_result", result,     64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("midrst_no_done", 64'(seen), 64'd0);
      run_op("after_rst", 1'b0, 32'd7, 32'd6, 64'd42, 1'b0, 32'h0, 32'h0);

      // Back-to-back random operations against a 64-bit reference product.
      for (int i = 0; i < 1000; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = $urandom;
         if (i % 16 == 0) ra = 32'h80000000;
         if (i % 23 == 0) rb = 32'hFFFFFFFF;
         if (rs) rexp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
         else    rexp = {32'd0, ra} * {32'd0, rb};
         run_op("rand", rs, ra, rb, rexp, 1'b0, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multiplier_sequential.md
MULTIPLIER_SEQUENTIAL -- requirements
Module: Multiplier_Sequential

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; legal range 2..64.
REQ-002 Port: Clock_In  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: Reset_N_In  input  1  reset, asynchronous and active-low.
REQ-004 Port: Start_In  input  1  request a multiply; accepted only while Ready_Out=1.
REQ-005 Port: Signed_In  input  1  mode select, sampled with Start_In: 1 = two's-complement operands, 0 = unsigned operands.
REQ-006 Port: Data_A_In  input  WIDTH  multiplicand, sampled on the accepting edge.
REQ-007 Port: Data_B_In  input  WIDTH  multiplier, sampled on the accepting edge.
REQ-008 Port: Ready_Out  output  1  block is idle and can accept Start_In.
REQ-009 Port: Done_Out  output  1  one-cycle pulse: Multiplied_Result_Out has just been updated.
REQ-010 Port: Multiplied_Result_Out  output  2*WIDTH  registered product of the last completed operation.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 In IDLE, Ready_Out SHALL be 1; in CALC and DONE, Ready_Out SHALL be 0.
REQ-013 Edge with IDLE and Start_In=1 (accept edge, E0): capture Signed_In; capture operand magnitudes (absolute value if signed, raw if unsigned); record result sign = sign(A) XOR sign(B) (0 if unsigned); clear partial product; load iteration counter with WIDTH; go to CALC.
REQ-014 Each CALC edge SHALL perform one radix-2 shift-add step: add the multiplicand to the upper half of the partial product when the current multiplier LSB is 1, shift right one bit with carry in, decrement the counter.
REQ-015 On the CALC edge where the counter goes from 1 to 0 (edge E0+WIDTH): load Multiplied_Result_Out with the product, two's-complement negated over 2*WIDTH bits if the result sign is 1; go to DONE.
REQ-016 Done_Out SHALL be 1 only in DONE, i.e. exactly one cycle, starting WIDTH cycles after E0; the next edge returns to IDLE.
REQ-017 Start_In SHALL be ignored in CALC and DONE; no queuing. The earliest next accept is edge E0+WIDTH+2.
REQ-018 Multiplied_Result_Out SHALL hold its value until the next REQ-015 load; it SHALL NOT change during CALC.
REQ-019 Signed mode: most negative operand (e.g. 0x80000000 at WIDTH=32) SHALL use magnitude 2^(WIDTH-1) as an unsigned WIDTH-bit value; the result SHALL be exact; no overflow is possible in 2*WIDTH bits.
REQ-020 A zero operand SHALL still take the full WIDTH cycles (fixed latency, no early exit).
REQ-021 Operand inputs SHALL be ignored outside the accept edge.

Reset
REQ-022 While Reset_N_In=0, asynchronously: state=IDLE, Ready_Out=1, Done_Out=0, Multiplied_Result_Out=0, counter and internal registers=0.
REQ-023 Reset asserted mid-CALC or in DONE SHALL abort the operation with no Done_Out pulse; after release, the first edge with Start_In=1 SHALL be accepted normally.

Verification (WIDTH=32)
REQ-024 Unsigned: A=3, B=5, Start 1 cycle -> Ready_Out=0 the next cycle; Done_Out=1 exactly 32 cycles after accept; result=0x000000000000000F; Ready_Out=1 one cycle later.
REQ-025 Unsigned: A=B=0xFFFFFFFF -> result=0xFFFFFFFE00000001. Signed: A=B=0xFFFFFFFF -> result=0x0000000000000001.
REQ-026 Signed: A=B=0x80000000 -> result=0x4000000000000000. Signed: A=0x80000000, B=1 -> result=0xFFFFFFFF80000000.
REQ-027 Start_In held high with new operands throughout CALC/DONE -> single Done_Out with the first operands' product; the held Start is accepted on the first IDLE edge; result unchanged during CALC.
REQ-028 Reset pulsed at cycle 10 of CALC -> outputs at reset values immediately; no Done_Out; a following A=7, B=6 operation yields 42 after 32 cycles.
REQ-029 Random: 1000 back-to-back ops, random Signed_In and operands -> each result matches the reference product.
